// File: rtl/lbm_pkg.sv
// Shared D2Q9 lattice definitions: direction encoding, unit offsets and the
// opposite-direction table used by bounce-back.
package lbm_pkg;

  typedef enum logic [3:0] {
    DIR_REST = 4'd0,
    DIR_E    = 4'd1,
    DIR_N    = 4'd2,
    DIR_W    = 4'd3,
    DIR_S    = 4'd4,
    DIR_NE   = 4'd5,
    DIR_NW   = 4'd6,
    DIR_SW   = 4'd7,
    DIR_SE   = 4'd8
  } dir_t;

  localparam int NUM_DIRS = 9;

  localparam logic signed [1:0] DX [NUM_DIRS] = '{
    2'sb00, 2'sb01, 2'sb00, 2'sb11, 2'sb00, 2'sb01, 2'sb11, 2'sb11, 2'sb01
  };

  localparam logic signed [1:0] DY [NUM_DIRS] = '{
    2'sb00, 2'sb00, 2'sb01, 2'sb00, 2'sb11, 2'sb01, 2'sb01, 2'sb11, 2'sb11
  };

  localparam dir_t OPP [NUM_DIRS] = '{
    DIR_REST, DIR_W, DIR_S, DIR_E, DIR_N, DIR_SW, DIR_SE, DIR_NE, DIR_NW
  };

endpackage

// File: rtl/lbm_neighbour_calc.sv
// Combinational neighbour lookup: applies a D2Q9 offset to (row, col) with
// power-of-two wrap, and flags when the row offset leaves the grid.
module lbm_neighbour_calc
  import lbm_pkg::*;
#(
  parameter int ROW_WIDTH = 4,
  parameter int COL_WIDTH = 4,
  parameter bit WALLS_EN  = 1'b0
) (
  input  logic [ROW_WIDTH-1:0]           row_i,
  input  logic [COL_WIDTH-1:0]           col_i,
  input  dir_t                           dir_i,
  output logic [ROW_WIDTH+COL_WIDTH-1:0] dst_o,
  output logic                           wall_o
);

  logic signed [1:0]    dx;
  logic signed [1:0]    dy;
  logic [ROW_WIDTH:0]   rowSum;
  logic [COL_WIDTH-1:0] colSum;

  // One extra row bit exposes both underflow (-1) and overflow (H) as its MSB.
  always_comb begin
    dx     = DX[dir_i];
    dy     = DY[dir_i];
    rowSum = {1'b0, row_i} + {{(ROW_WIDTH-1){dy[1]}}, dy};
    colSum = col_i + {{(COL_WIDTH-2){dx[1]}}, dx};
    dst_o  = {rowSum[ROW_WIDTH-1:0], colSum};
    wall_o = WALLS_EN && rowSum[ROW_WIDTH];
  end

endmodule

// File: rtl/lbm_stream_addr_gen.sv
// D2Q9 streaming address generator: one cell in, nine (src, dst, dir) beats out.
// Define LBM_BOUNCE_BACK_EN to turn rows 0 and H-1 into no-slip bounce-back walls.
module lbm_stream_addr_gen
  import lbm_pkg::*;
#(
  parameter int GRID_DIM      = 256,
  parameter int GRID_W        = 16,
  parameter int ADDRESS_WIDTH = $clog2(GRID_DIM),
  parameter int ROW_WIDTH     = $clog2(GRID_DIM / GRID_W),
  parameter int COL_WIDTH     = $clog2(GRID_W)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     enable_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [ADDRESS_WIDTH-1:0] cell_addr_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [3:0]               dir_o,
  output logic [ADDRESS_WIDTH-1:0] src_addr_o,
  output logic [ADDRESS_WIDTH-1:0] dst_addr_o,
  output logic                     last_dir_o,
  output logic                     bounce_o,
  output logic                     frame_done_o
);

`ifdef LBM_BOUNCE_BACK_EN
  localparam bit WallsEn = 1'b1;
`else
  localparam bit WallsEn = 1'b0;
`endif

  localparam logic [ADDRESS_WIDTH-1:0] LastAddr = ADDRESS_WIDTH'(GRID_DIM - 1);

  typedef enum logic {
    ST_IDLE,
    ST_GEN
  } state_t;

  state_t                     state_q;
  dir_t                       dir_q;
  logic [ADDRESS_WIDTH-1:0]   src_q;
  logic                       frame_q;

  logic                       outValid;
  logic                       lastBeat;
  logic                       beatAccept;
  logic                       takeCell;
  logic [ADDRESS_WIDTH-1:0]   nbrDst;
  logic                       wallCross;

  assign outValid   = (state_q == ST_GEN);
  assign lastBeat   = (dir_q == DIR_SE);
  assign beatAccept = enable_i && outValid && out_ready_i;
  assign in_ready_o = enable_i && ((state_q == ST_IDLE) || (outValid && out_ready_i && lastBeat));
  assign takeCell   = in_ready_o && in_valid_i;

  // Taking a new cell on the final beat's handshake keeps back-to-back cells bubble-free.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_REST;
      src_q   <= '0;
      frame_q <= 1'b0;
    end else if (enable_i) begin
      frame_q <= beatAccept && lastBeat && (src_q == LastAddr);
      if (takeCell) begin
        src_q   <= cell_addr_i;
        dir_q   <= DIR_REST;
        state_q <= ST_GEN;
      end else if (beatAccept) begin
        if (lastBeat) begin
          state_q <= ST_IDLE;
        end else begin
          dir_q <= dir_t'(dir_q + 4'd1);
        end
      end
    end else begin
      frame_q <= 1'b0;
    end
  end

  lbm_neighbour_calc #(
    .ROW_WIDTH (ROW_WIDTH),
    .COL_WIDTH (COL_WIDTH),
    .WALLS_EN  (WallsEn)
  ) u_neighbour (
    .row_i  (src_q[ADDRESS_WIDTH-1:COL_WIDTH]),
    .col_i  (src_q[COL_WIDTH-1:0]),
    .dir_i  (dir_q),
    .dst_o  (nbrDst),
    .wall_o (wallCross)
  );

  // A wall-crossing beat reflects back into the source cell along the opposite link.
  assign out_valid_o  = outValid;
  assign src_addr_o   = src_q;
  assign dst_addr_o   = wallCross ? src_q : nbrDst;
  assign dir_o        = wallCross ? OPP[dir_q] : dir_q;
  assign bounce_o     = outValid && wallCross;
  assign last_dir_o   = outValid && lastBeat;
  assign frame_done_o = frame_q && enable_i;

endmodule

// File: tb/tb_lbm_stream_addr_gen.sv
// Testbench for lbm_stream_addr_gen: directed literal cases plus randomized
// traffic compared every cycle against a beat-queue reference model.
module tb_lbm_stream_addr_gen;

  localparam int GRID_DIM = 256;
  localparam int GRID_W   = 16;
  localparam int H        = GRID_DIM / GRID_W;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       enable_i = 1'b0;
  logic       in_valid_i = 1'b0;
  logic       out_ready_i = 1'b0;
  logic [7:0] cell_addr_i = '0;
  logic       in_ready_o;
  logic       out_valid_o;
  logic [3:0] dir_o;
  logic [7:0] src_addr_o;
  logic [7:0] dst_addr_o;
  logic       last_dir_o;
  logic       bounce_o;
  logic       frame_done_o;

  lbm_stream_addr_gen #(
    .GRID_DIM (GRID_DIM),
    .GRID_W   (GRID_W)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .enable_i     (enable_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .cell_addr_i  (cell_addr_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .dir_o        (dir_o),
    .src_addr_o   (src_addr_o),
    .dst_addr_o   (dst_addr_o),
    .last_dir_o   (last_dir_o),
    .bounce_o     (bounce_o),
    .frame_done_o (frame_done_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int dir;
    int src;
    int dst;
    bit last;
    bit bnc;
  } beat_t;

  beat_t expQ[$];
  bit    framePend = 1'b0;
  bit    mv;
  bit    expReady;
  bit    fire;
  bit    nextFrame;

  int DXT [9]  = '{0, 1, 0, -1, 0, 1, -1, -1, 1};
  int DYT [9]  = '{0, 0, 1, 0, -1, 1, 1, -1, -1};
  int OPPT [9] = '{0, 3, 4, 1, 2, 7, 8, 5, 6};

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit ena, input bit iv, input int addr, input bit ordy);
    enable_i    = ena;
    in_valid_i  = iv;
    cell_addr_i = 8'(addr);
    out_ready_i = ordy;
  endtask

  // Reference beat: plain row/col arithmetic with explicit modulo.
  function automatic beat_t modelBeat(input int addr, input int d);
    beat_t b;
    int    row;
    int    col;
    int    nr;
    int    nc;
    row    = addr / GRID_W;
    col    = addr % GRID_W;
    nr     = row + DYT[d];
    nc     = (col + DXT[d] + GRID_W) % GRID_W;
    b.dir  = d;
    b.src  = addr;
    b.last = (d == 8);
    b.bnc  = 1'b0;
    b.dst  = ((nr + H) % H) * GRID_W + nc;
`ifdef LBM_BOUNCE_BACK_EN
    if (nr < 0 || nr >= H) begin
      b.dst = addr;
      b.dir = OPPT[d];
      b.bnc = 1'b1;
    end
`endif
    return b;
  endfunction

  // Every cycle, compare the DUT against the model, then advance the model.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      expQ.delete();
      framePend = 1'b0;
      checkOutput("rst out_valid", out_valid_o, 0);
      checkOutput("rst dir", dir_o, 0);
      checkOutput("rst src", src_addr_o, 0);
      checkOutput("rst dst", dst_addr_o, 0);
      checkOutput("rst last", last_dir_o, 0);
      checkOutput("rst bounce", bounce_o, 0);
      checkOutput("rst frame", frame_done_o, 0);
      checkOutput("rst in_ready", in_ready_o, enable_i);
    end else begin
      mv = (expQ.size() > 0);
      checkOutput("out_valid", out_valid_o, mv);
      if (mv) begin
        checkOutput("dir", dir_o, expQ[0].dir);
        checkOutput("src", src_addr_o, expQ[0].src);
        checkOutput("dst", dst_addr_o, expQ[0].dst);
        checkOutput("last_dir", last_dir_o, expQ[0].last);
        checkOutput("bounce", bounce_o, expQ[0].bnc);
      end
      expReady = enable_i && (!mv || (out_ready_i && expQ[0].last));
      checkOutput("in_ready", in_ready_o, expReady);
      checkOutput("frame_done", frame_done_o, framePend && enable_i);
      fire      = enable_i && mv && out_ready_i;
      nextFrame = 1'b0;
      if (fire) begin
        nextFrame = expQ[0].last && (expQ[0].src == GRID_DIM - 1);
        void'(expQ.pop_front());
      end
      if (expReady && in_valid_i) begin
        for (int d = 0; d < 9; d++) expQ.push_back(modelBeat(int'(cell_addr_i), d));
      end
      framePend = enable_i ? nextFrame : 1'b0;
    end
  end

  int dIdent [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
  int zeros  [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
  int dst17  [9] = '{17, 18, 33, 16, 1, 34, 32, 0, 2};
  int dst0   [9];
  int dir0   [9];
  int bnc0   [9];
  int dst255 [9];
  int dir255 [9];
  int bnc255 [9];
  int dst250 [9];
  int dst5   [9];

  task automatic acceptCell(input int addr, output bit ok);
    bit acc;
    ok = 1'b0;
    applyStimulus(1, 1, addr, 1);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk_i);
      acc = in_ready_o;
      @(posedge clk_i);
      #1;
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid_i = 1'b0;
    if (!ok) checkOutput($sformatf("accept timeout cell %0d", addr), 0, 1);
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (out_valid_o && n < 50) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    checkOutput("drain to idle", out_valid_o, 0);
  endtask

  // Beat k is visible just after the k-th edge following acceptance.
  task automatic runCell(input int addr, input int eDst[9], input int eDir[9], input int eBnc[9]);
    bit ok;
    acceptCell(addr, ok);
    if (!ok) return;
    for (int k = 0; k < 9; k++) begin
      checkOutput($sformatf("c%0d k%0d valid", addr, k), out_valid_o, 1);
      checkOutput($sformatf("c%0d k%0d dst", addr, k), dst_addr_o, eDst[k]);
      checkOutput($sformatf("c%0d k%0d dir", addr, k), dir_o, eDir[k]);
      checkOutput($sformatf("c%0d k%0d bounce", addr, k), bounce_o, eBnc[k]);
      checkOutput($sformatf("c%0d k%0d last", addr, k), last_dir_o, (k == 8) ? 1 : 0);
      @(posedge clk_i);
      #1;
    end
    checkOutput($sformatf("c%0d idle after", addr), out_valid_o, 0);
  endtask

  task automatic stallTest(input bit useEnable);
    bit ok;
    int n;
    acceptCell(17, ok);
    if (!ok) return;
    n = 0;
    while (dir_o != 4'd4 && n < 20) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    checkOutput("stall reach dir4", dir_o, 4);
    if (useEnable) enable_i = 1'b0;
    else out_ready_i = 1'b0;
    repeat (useEnable ? 2 : 3) begin
      @(posedge clk_i);
      #1;
      checkOutput("stall hold dir", dir_o, 4);
      checkOutput("stall hold dst", dst_addr_o, 1);
      checkOutput("stall hold valid", out_valid_o, 1);
    end
    enable_i    = 1'b1;
    out_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    checkOutput("stall release dir5", dir_o, 5);
    checkOutput("stall release dst", dst_addr_o, 34);
    waitIdle();
  endtask

  int  addr;
  int  validCnt;
  int  frames;
  int  firstV;
  int  frameCyc;
  bit  acc;

  initial begin
`ifdef LBM_BOUNCE_BACK_EN
    dst0   = '{0, 1, 16, 15, 0, 17, 31, 0, 0};
    dir0   = '{0, 1, 2, 3, 2, 5, 6, 5, 6};
    bnc0   = '{0, 0, 0, 0, 1, 0, 0, 1, 1};
    dst255 = '{255, 240, 255, 254, 239, 255, 255, 238, 224};
    dir255 = '{0, 1, 4, 3, 4, 7, 8, 7, 8};
    bnc255 = '{0, 0, 1, 0, 0, 1, 1, 0, 0};
    dst250 = '{250, 251, 250, 249, 234, 250, 250, 233, 235};
    dst5   = '{5, 6, 21, 4, 5, 22, 20, 5, 5};
`else
    dst0   = '{0, 1, 16, 15, 240, 17, 31, 255, 241};
    dir0   = dIdent;
    bnc0   = zeros;
    dst255 = '{255, 240, 15, 254, 239, 0, 14, 238, 224};
    dir255 = dIdent;
    bnc255 = zeros;
    dst250 = '{250, 251, 10, 249, 234, 11, 9, 233, 235};
    dst5   = '{5, 6, 21, 4, 245, 22, 20, 244, 246};
`endif

    applyStimulus(0, 0, 0, 0);
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni   = 1'b1;
    enable_i = 1'b1;
    @(posedge clk_i);
    #1;
    checkOutput("post-reset in_ready", in_ready_o, 1);
    checkOutput("post-reset out_valid", out_valid_o, 0);
    checkOutput("post-reset frame_done", frame_done_o, 0);

    runCell(17, dst17, dIdent, zeros);
    runCell(0, dst0, dir0, bnc0);
    runCell(255, dst255, dir255, bnc255);
    runCell(250, dst250, dir255, bnc255);
    runCell(5, dst5, dir0, bnc0);

    stallTest(1'b0);
    stallTest(1'b1);

    // Asynchronous reset in the middle of a cell.
    acceptCell(17, acc);
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    #1;
    checkOutput("mid-gen reset out_valid", out_valid_o, 0);
    checkOutput("mid-gen reset src", src_addr_o, 0);
    checkOutput("mid-gen reset dir", dir_o, 0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Full frame from a cell counter with the consumer always ready.
    addr = 0;
    applyStimulus(1, 1, 0, 1);
    validCnt = 0;
    frames   = 0;
    firstV   = -1;
    frameCyc = -1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk_i);
      acc = in_ready_o && in_valid_i;
      @(posedge clk_i);
      #1;
      if (acc) begin
        if (addr == GRID_DIM - 1) in_valid_i = 1'b0;
        else addr++;
        cell_addr_i = 8'(addr);
      end
      if (out_valid_o) begin
        validCnt++;
        if (firstV < 0) firstV = cyc;
      end
      if (frame_done_o) begin
        frames++;
        frameCyc = cyc;
      end
      if (frameCyc >= 0 && cyc > frameCyc + 2) break;
    end
    checkOutput("frame beat count", validCnt, 2304);
    checkOutput("frame_done pulses", frames, 1);
    checkOutput("frame span no bubbles", frameCyc - firstV, 2304);

    // Randomized traffic; the compare process does all checking here.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk_i);
      #1;
      applyStimulus($urandom_range(0, 9) != 0,
                    $urandom_range(0, 9) < 6,
                    ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 255)),
                    $urandom_range(0, 3) != 0);
    end
    applyStimulus(1, 0, 0, 1);
    repeat (20) @(posedge clk_i);
    #1;
    checkOutput("final idle", out_valid_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/lbm_stream_addr_gen.md
Name: lbm_stream_addr_gen

Overview:
- Downstream of the grid cell counter (linear address 0..GRID_DIM-1) and the row counter.
- Consumes one linear cell address per handshake and emits, one beat per direction, the D2Q9 streaming pairs (source address, destination neighbour address, direction).
- Periodic boundaries by default.
- Output feeds the distribution-memory write-address path of the streaming step.

Parameters:
- GRID_DIM, 256, total cells; power of two.
- GRID_W, 16, cells per row; power of two; GRID_DIM/GRID_W rows.
- ADDRESS_WIDTH, $clog2(GRID_DIM), linear address width.
- ROW_WIDTH, $clog2(GRID_DIM/GRID_W), row index width.
- COL_WIDTH, $clog2(GRID_W), column index width.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Enable  in  1  global advance enable; low freezes all state.
- In_valid  in  1  Cell_addr valid.
- In_ready  out  1  block can accept a cell this cycle.
- Cell_addr  in  ADDRESS_WIDTH  linear cell address (row*GRID_W+col).
- Out_valid  out  1  output beat valid.
- Out_ready  in  1  consumer accepts beat.
- Dir  out  4  D2Q9 direction 0..8.
- Src_addr  out  ADDRESS_WIDTH  cell being streamed.
- Dst_addr  out  ADDRESS_WIDTH  neighbour receiving direction Dir.
- Last_dir  out  1  high on the Dir==8 beat.
- Bounce  out  1  destination replaced by bounce-back (see Optional Feature).
- Frame_done  out  1  one-cycle pulse when the final beat of cell GRID_DIM-1 is accepted.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low (Reset==0 clears immediately).
- Reset values:
  - State=IDLE, In_ready=1, Out_valid=0.
  - Dir=0, Src_addr=0, Dst_addr=0.
  - Last_dir=0, Bounce=0, Frame_done=0.
- Direction order and offsets (dx,dy):
  - 0 rest (0,0), 1 E (+1,0), 2 N (0,+1), 3 W (-1,0), 4 S (0,-1).
  - 5 NE (+1,+1), 6 NW (-1,+1), 7 SW (-1,-1), 8 SE (+1,-1).
- Arithmetic:
  - row=Cell_addr>>COL_WIDTH; col=Cell_addr[COL_WIDTH-1:0].
  - Dst = ((row+dy) mod H)<<COL_WIDTH | ((col+dx) mod GRID_W).
  - The modulo is natural truncation to ROW_WIDTH/COL_WIDTH bits.
  - No dividers.
- FSM:
  - IDLE: In_ready=1. On Enable&&In_valid, latch Cell_addr and go to GEN. Next cycle Out_valid=1 with Dir=0, so latency is 1 cycle.
  - GEN: Out_valid=1. On Enable&&Out_ready, Dir increments.
  - On acceptance of Dir==8: if In_valid, take the next cell with no bubble (In_ready=1 in that cycle) and restart at Dir 0; otherwise return to IDLE with Out_valid=0.
  - Throughput: 9 beats per cell back-to-back.
- In_ready is combinational: (State==IDLE) || (Out_valid && Out_ready && Dir==8), ANDed with Enable.
- Output stability: while Out_valid && !Out_ready, all outputs hold stable.
- Enable=0: no acceptance, no Dir advance, outputs held, Frame_done forced 0.
- Frame_done: asserted the cycle after the Dir==8 beat of Src_addr==GRID_DIM-1 is accepted; cleared the next cycle.
- Wrap-around: address GRID_DIM-1 followed by 0 is legal and needs no special handling.
- Reset mid-beat: outputs drop to reset values asynchronously and the partially emitted cell is discarded.

Optional Feature:
- Macro: LBM_BOUNCE_BACK_EN.
- Defined (bounce-back walls):
  - Rows 0 and H-1 are no-slip walls.
  - Applies to any beat where row+dy leaves 0..H-1.
  - On such a beat: Dst_addr=Src_addr, Dir reports OPP[dir] (1<->3, 2<->4, 5<->7, 6<->8), Bounce=1.
  - Columns stay periodic.
- Undefined: all boundaries periodic, Bounce tied 0. Port list is identical in both builds.

Decomposition:
- Package lbm_pkg:
  - dir_t enum (DIR_REST..DIR_SE, 4 bits), NUM_DIRS=9.
  - DX[9]/DY[9] signed 2-bit constant arrays, OPP[9] table.
- Sub-module lbm_neighbour_calc (combinational):
  - Inputs: row, col, dir. Outputs: dst address, wall-crossing flag.
  - Instantiated once; the FSM and handshake live in the top.

Test Plan:
1. Reset, then deassert with In_valid=0 -> In_ready=1, Out_valid=0, Frame_done=0. Assert Reset low mid-GEN -> Out_valid=0 in the same cycle.
2. Cell 17 (row1,col1), Out_ready=1 -> Dst per Dir 0..8 = 17,18,33,16,1,34,32,0,2. Last_dir only on Dir 8; Out_valid rises 1 cycle after accept.
3. Cell 0, periodic build -> Dir3 Dst=15, Dir4 Dst=240, Dir7 Dst=255, Dir8 Dst=241. Cell 255: Dir1 Dst=240, Dir5 Dst=0.
4. Cell 17, Out_ready low 3 cycles at Dir 4 -> Dir=4, Dst=1 held stable; Dir 5 follows one cycle after Out_ready rises. Enable low 2 cycles behaves identically.
5. Full frame driven by the cell counter 0..255, Out_ready=1 -> 2304 beats with zero bubbles between cells; Frame_done exactly once, after the addr-255 Dir-8 beat.
6. LBM_BOUNCE_BACK_EN:
   - Cell 250 Dir 2 -> Dst=250, Dir=4, Bounce=1.
   - Cell 5 Dir 7 -> Dst=5, Dir=5, Bounce=1.
   - Cell 5 Dir 3 -> Dst=4, Bounce=0.
